// File: rtl/prio_scan_pkg.sv
// Shared definitions for the priority scan encoder.
//   state_e : FSM encoding (IDLE, SCAN)
//   clog2   : constant-evaluable ceil(log2(n)) for index widths
package prio_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-to-W priority encoder with selectable scan direction.
//   vec       : input bit vector
//   lsb_first : 1 = lowest set bit wins, 0 = highest set bit wins
//   idx       : index of winning bit (0 when vec is all zero)
//   any       : at least one bit of vec is set
module prio_enc_n
  import prio_scan_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic         lsb_first,
  output logic [W-1:0] idx,
  output logic         any
);

  // Last assignment in loop order wins, so the loop direction picks
  // which end of the vector has priority.
  always_comb begin
    idx = '0;
    any = |vec;
    if (lsb_first) begin
      for (int i = N - 1; i >= 0; i--)
        if (vec[i]) idx = W'(i);
    end else begin
      for (int i = 0; i < N; i++)
        if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/prio_scan_enc.sv
// Priority scan encoder: accepts an N-bit request vector, then emits the
// index of each set bit, one per output handshake, in priority order.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : vector input handshake (ready only in IDLE)
//   req, lsb_first     : request vector and scan order, latched on accept
//   out_valid/out_ready: index output handshake
//   out_idx, out_last  : current winner, final-bit flag
//   zero_req           : one-cycle pulse after an all-zero vector is accepted
//   pend_cnt           : number of bits still pending
module prio_scan_enc
  import prio_scan_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  input  logic         lsb_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_req,
  output logic [W:0]   pend_cnt
);

  state_e       state, state_nxt;
  logic [N-1:0] pend, pend_nxt;
  logic         order, order_nxt;
  logic         zr_nxt;
  logic [W-1:0] win;
  logic         any;
  logic [W:0]   cnt;

  prio_enc_n #(.N(N), .W(W)) u_enc (
    .vec       (pend),
    .lsb_first (order),
    .idx       (win),
    .any       (any)
  );

  // Count is derived from pend itself so it can never drift from it.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++)
      cnt = cnt + {{W{1'b0}}, pend[i]};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SCAN);
  assign out_idx   = win;
  assign pend_cnt  = cnt;
  assign out_last  = (cnt == (W+1)'(1));

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    order_nxt = order;
    zr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          pend_nxt  = req;
          order_nxt = lsb_first;
          if (|req) state_nxt = SCAN;
          else      zr_nxt    = 1'b1;
        end
      end
      SCAN: begin
        if (out_ready && any) begin
          pend_nxt = pend & ~(N'(1) << win);
          if (out_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      order    <= 1'b0;
      zero_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      order    <= order_nxt;
      zero_req <= zr_nxt;
    end
  end

endmodule

// File: tb/tb_prio_scan_enc.sv
module tb_prio_scan_enc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=8 instance
  logic       iv8, lf8, or8, ir8, ov8, last8, zr8;
  logic [7:0] rq8;
  logic [2:0] idx8;
  logic [3:0] cnt8;
  // N=64 instance
  logic        iv64, lf64, or64, ir64, ov64, last64, zr64;
  logic [63:0] rq64;
  logic [5:0]  idx64;
  logic [6:0]  cnt64;

  prio_scan_enc #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .req(rq8),
    .lsb_first(lf8), .out_valid(ov8), .out_ready(or8), .out_idx(idx8),
    .out_last(last8), .zero_req(zr8), .pend_cnt(cnt8)
  );

  prio_scan_enc #(.N(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .req(rq64),
    .lsb_first(lf64), .out_valid(ov64), .out_ready(or64), .out_idx(idx64),
    .out_last(last64), .zero_req(zr64), .pend_cnt(cnt64)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the set of bits still owed to the consumer, the
  // latched order, and the pending zero pulse. Busy == set is non-empty.
  logic [63:0] mp [2];
  logic        mo [2];
  logic        mz [2];
  int          hs64;

  function automatic int winner(input int d);
    if (mp[d] == 64'd0) return 0;
    if (mo[d]) begin
      for (int i = 0; i < 64; i++) if (mp[d][i]) return i;
    end else begin
      for (int i = 63; i >= 0; i--) if (mp[d][i]) return i;
    end
    return 0;
  endfunction

  task automatic check_dut(input int d, input logic ir, input logic ov,
                           input logic [63:0] idx, input logic last,
                           input logic zr, input logic [63:0] cnt);
    string p;
    logic  busy;
    int    c;
    p    = (d == 0) ? "n8" : "n64";
    busy = (mp[d] != 64'd0);
    c    = $countones(mp[d]);
    chk({p, ".in_ready"},  64'(ir),   64'(!busy));
    chk({p, ".out_valid"}, 64'(ov),   64'(busy));
    chk({p, ".out_idx"},   idx,       64'(winner(d)));
    chk({p, ".pend_cnt"},  cnt,       64'(c));
    chk({p, ".out_last"},  64'(last), 64'(c == 1));
    chk({p, ".zero_req"},  64'(zr),   64'(mz[d]));
  endtask

  task automatic model_next(input int d, input logic iv, input logic [63:0] rq,
                            input logic lf, input logic ordy,
                            output logic [63:0] np, output logic no, output logic nz);
    np = mp[d]; no = mo[d]; nz = 1'b0;
    if (rst) begin
      np = '0; no = 1'b0;
    end else if (mp[d] == 64'd0) begin
      if (iv) begin
        np = rq; no = lf; nz = (rq == 64'd0);
      end
    end else if (ordy) begin
      np[winner(d)] = 1'b0;
    end
  endtask

  // One cycle: compare registered outputs against the model, advance the
  // model with the inputs presented, then step past the edge.
  task automatic step();
    logic [63:0] np0, np1;
    logic        no0, no1, nz0, nz1;
    check_dut(0, ir8, ov8, 64'(idx8), last8, zr8, 64'(cnt8));
    check_dut(1, ir64, ov64, 64'(idx64), last64, zr64, 64'(cnt64));
    if (!rst && ov64 && or64) hs64++;
    model_next(0, iv8, 64'(rq8), lf8, or8, np0, no0, nz0);
    model_next(1, iv64, rq64, lf64, or64, np1, no1, nz1);
    @(posedge clk);
    #1;
    mp[0] = np0; mo[0] = no0; mz[0] = nz0;
    mp[1] = np1; mo[1] = no1; mz[1] = nz1;
  endtask

  task automatic idle_inputs();
    iv8 = 0; rq8 = '0; lf8 = 0; or8 = 0;
    iv64 = 0; rq64 = '0; lf64 = 0; or64 = 0;
  endtask

  task automatic run8(input logic [7:0] v, input logic lf, input int n);
    iv8 = 1; rq8 = v; lf8 = lf; or8 = 1;
    step();
    iv8 = 0; rq8 = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin mp[d] = '0; mo[d] = 0; mz[d] = 0; end
    hs64 = 0;
    step();
    rst = 0;
    step();
    step();

    // Directed: msb-first, lsb-first, zero vector
    run8(8'b1010_0100, 1'b0, 5);
    run8(8'b1010_0100, 1'b1, 5);
    run8(8'h00, 1'b0, 3);

    // All ones with stalls in pattern 1,0,0,1
    iv8 = 1; rq8 = 8'hFF; lf8 = 0; or8 = 0;
    step();
    iv8 = 0;
    for (int k = 0; k < 40; k++) begin
      or8 = ((k % 4) == 0) || ((k % 4) == 3);
      step();
    end
    or8 = 0;

    // Reset while a result is stalled, then a fresh vector
    iv8 = 1; rq8 = 8'h81; lf8 = 0; or8 = 0;
    step();
    iv8 = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    run8(8'h02, 1'b0, 3);

    // N=64 all ones, always ready
    iv64 = 1; rq64 = '1; lf64 = 0; or64 = 1;
    step();
    iv64 = 0; rq64 = '0;
    hs64 = 0;
    for (int i = 0; i < 70; i++) step();
    chk("n64.handshakes", 64'(hs64), 64'd64);

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      iv8  = $urandom_range(0, 3) != 0;
      rq8  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      lf8  = $urandom_range(0, 1) != 0;
      or8  = $urandom_range(0, 2) != 0;
      iv64 = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 3))
        0:       rq64 = '0;
        1:       rq64 = 64'(1) << $urandom_range(0, 63);
        2:       rq64 = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
        default: rq64 = {32'($urandom), 32'($urandom)};
      endcase
      lf64 = $urandom_range(0, 1) != 0;
      or64 = $urandom_range(0, 4) != 0;
      rst  = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/prio_scan_enc.md
PRIO_SCAN_ENC -- requirements
Module: prio_scan_enc

Interface
REQ-001 Parameter N, default 8: number of request bits, legal range 2..64.
REQ-002 Parameter W, default $clog2(N): index width; not overridden by instantiators.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request vector offered.
REQ-006 in_ready  output  1  block can accept a vector; high only in IDLE.
REQ-007 req  input  N  request vector; bit N-1 is highest priority unless lsb_first is set.
REQ-008 lsb_first  input  1  scan-order select, sampled only on acceptance; 1 = bit 0 first.
REQ-009 out_valid  output  1  out_idx holds a pending index.
REQ-010 out_ready  input  1  consumer takes out_idx.
REQ-011 out_idx  output  W  index of the current winning bit.
REQ-012 out_last  output  1  out_idx is the final pending bit of the vector.
REQ-013 zero_req  output  1  one-cycle pulse: an all-zero vector was accepted.
REQ-014 pend_cnt  output  W+1  count of bits still pending.

Function
REQ-015 States: IDLE and SCAN only.
REQ-016 IDLE: in_ready=1, out_valid=0.
REQ-017 Acceptance: in_valid && in_ready at edge t; req latched into pending register, lsb_first latched into order register.
REQ-018 Nonzero req accepted at t: state=SCAN and out_valid=1 from cycle t+1 (latency one cycle).
REQ-019 Zero req accepted at t: state stays IDLE, zero_req=1 for cycle t+1 only, no out_valid.
REQ-020 SCAN, msb-first order: out_idx = highest set pending bit; lsb-first order: lowest set pending bit.
REQ-021 out_idx, out_last, pend_cnt are functions of the registered pending/order state only; no combinational path from req/in_valid to any output.
REQ-022 out_valid && out_ready at edge: the out_idx bit is cleared in pending; pend_cnt decrements by 1.
REQ-023 out_valid && !out_ready: out_idx, out_last, pending held stable (no retraction, no change).
REQ-024 out_last = 1 exactly when pend_cnt == 1.
REQ-025 Handshake with out_last=1: next state IDLE, in_ready=1 the following cycle; no back-to-back acceptance in the same cycle.
REQ-026 Vector with k set bits yields exactly k handshakes, each index once, in strict priority order.
REQ-027 pend_cnt = popcount of the pending register; 0 in IDLE.
REQ-028 in_valid in SCAN is ignored; req is not sampled.
REQ-029 All-ones vector with N=64: pend_cnt=64 representable in W+1 bits.

Reset
REQ-030 rst high at edge: state=IDLE, pending=0, order=0, zero_req=0; outputs in_ready=1, out_valid=0, out_idx=0, out_last=0, pend_cnt=0 from the next cycle.
REQ-031 rst overrides any simultaneous acceptance or output handshake; a scan in progress is discarded without further outputs.
REQ-032 Outputs after rst deassertion match REQ-016 until the first acceptance.

Structure
REQ-033 Shared package/header prio_scan_pkg holds the state encoding localparams (IDLE, SCAN) and the clog2 helper function.
REQ-034 Sub-module prio_enc_n: purely combinational parametrised N-to-W priority encoder with direction input and any-bit flag; instantiated once, on the pending register.
REQ-035 Popcount is computed combinationally from the pending register; no separate counter that can diverge from it.

Verification
REQ-036 N=8, req=8'b1010_0100, lsb_first=0, out_ready=1 always -> out_idx 7,5,2 on consecutive cycles, out_last on idx 2, in_ready high the following cycle.
REQ-037 Same req, lsb_first=1 -> out_idx 2,5,7; pend_cnt 3,2,1.
REQ-038 req=8'h00 accepted -> zero_req single pulse, out_valid never asserts, in_ready stays 1.
REQ-039 req=8'hFF, out_ready toggled 1,0,0,1... -> out_idx held during stalls, all 8 indices 7..0 exactly once, pend_cnt never skips.
REQ-040 req=8'h81 accepted, rst asserted while out_idx=7 awaiting ready -> next cycle out_valid=0, in_ready=1, pend_cnt=0; new req=8'h02 gives out_idx=1.
REQ-041 N=64, req all ones -> pend_cnt=64 first cycle, 64 handshakes, out_idx 63..0.
